branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumer side of the branch prediction path. Records each prediction issued at IF in an in-order in-flight queue.
//  When EX resolves a branch (equal/not-equal known), compares the outcome against the oldest recorded prediction.
//  On mismatch: raises a one-cycle flush and redirect PC. Always returns the actual outcome to the predictor FSM
//  (upd_valid/upd_taken) and keeps saturating statistics counters.
// PARAMETERS
//  ADDR_W  32  PC/target width in bits
//  DEPTH   4   in-flight prediction entries; power of 2, >=2
//  CNT_W   16  statistics counter width
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       synchronous, active-high reset
//  stall          in   1       pipeline stall: no push, no pop, pulse outputs forced 0
//  pred_valid     in   1       IF issues a branch prediction this cycle (push)
//  pred_taken     in   1       predicted direction (1 = taken)
//  pred_target    in   ADDR_W  predicted taken target
//  pred_fallthru  in   ADDR_W  sequential PC (branch PC + 4)
//  res_valid      in   1       EX resolves the oldest in-flight branch (pop)
//  res_taken      in   1       actual direction (equal_or_not for beq)
//  res_target     in   ADDR_W  actual computed target
//  full           out  1       queue holds DEPTH entries; IF must not push
//  flush          out  1       1-cycle pulse: squash wrong-path instructions
//  redirect_pc    out  ADDR_W  correct PC, valid when flush=1
//  upd_valid      out  1       1-cycle pulse: predictor state update
//  upd_taken      out  1       actual direction for the update
//  branch_cnt     out  CNT_W   resolved branches, saturating
//  mispred_cnt    out  CNT_W   mispredictions, saturating
//  err_flag       out  1       sticky: push-on-full or pop-on-empty seen
// BEHAVIOUR
//  Reset: queue empty, rd/wr pointers 0, full=0, flush=0, redirect_pc=0, upd_valid=0, upd_taken=0,
//   both counters 0, err_flag=0. Reset mid-operation discards all in-flight entries immediately.
//  Push (pred_valid & ~stall & ~full): store {pred_taken, pred_target, pred_fallthru} at wr_ptr.
//  Pop (res_valid & ~stall & ~empty): read the entry at rd_ptr and evaluate it.
//  Mispredict when:
//   - pred_taken != res_taken, or
//   - both taken and pred_target != res_target.
//  Correct PC = res_taken ? res_target : entry.fallthru.
//  Latency: results are registered. Pop at cycle N -> flush/redirect_pc/upd_* valid at N+1, for exactly 1 cycle.
//   - upd_valid=1, upd_taken=res_taken on every pop.
//   - flush=1 only on a mispredict.
//  redirect_pc holds its last value when flush=0.
//  Counters: branch_cnt += 1 per pop; mispred_cnt += 1 per mispredict. Both stick at all-ones (no wrap).
//  Mispredict pop: the whole queue is cleared in the same edge (all younger entries are wrong-path).
//   A push in the same cycle is discarded.
//  Push and pop in the same cycle without mispredict: both take effect; occupancy unchanged; legal when full.
//  Push when full with no pop: ignored, err_flag <= 1. Pop when empty: ignored, no pulses, err_flag <= 1.
//  stall=1: queue, pointers and counters hold; flush/upd_valid are 0 on the following cycle.
//  Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
//   full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
// STRUCTURE
//  Shared header branch_defs.vh:
//   - ADDR_W default.
//   - Entry field offsets and entry width (1 + 2*ADDR_W).
//   - Direction encodings TAKEN=1'b1, NOT_TAKEN=1'b0, shared with the predictor.
//  Sub-module bru_pred_fifo: circular queue (push, pop, clear, full, empty, rd_data).
//  Top level holds the compare logic, output registers and counters.
// TESTING
//  1. Reset, then push {T, 0x100, 0x24}; pop with res_taken=1, res_target=0x100
//     -> next cycle upd_valid=1, upd_taken=1, flush=0; branch_cnt=1, mispred_cnt=0.
//  2. Push {NT, 0x200, 0x40}; pop with res_taken=1, res_target=0x200
//     -> flush=1, redirect_pc=0x200 for one cycle; mispred_cnt=1.
//  3. Push {T, 0x300, 0x50}; pop with res_taken=0 -> flush=1, redirect_pc=0x50.
//  4. Push 3 entries; mispredict on the first pop while pushing a 4th in the same cycle
//     -> queue empty, full=0; a later pop sets err_flag=1 and produces no pulses.
//  5. Fill to DEPTH=4 -> full=1; push alone -> err_flag=1, contents unchanged.
//     Then simultaneous push+pop with correct prediction -> full stays 1; 4 more pops return entries in order.
//  6. stall=1 with pred_valid=res_valid=1 -> no state change, no pulses.
//     Then assert rst mid-queue -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve path: direction encodings shared with
// the predictor, and the layout of one in-flight prediction entry.
package branch_resolve_unit_pkg;

    localparam int   DEF_ADDR_W = 32;

    localparam logic TAKEN     = 1'b1;
    localparam logic NOT_TAKEN = 1'b0;

    // Entry layout, MSB first: {taken, target, fallthru}
    function automatic int entry_w(input int addr_w);
        return 1 + 2 * addr_w;
    endfunction

    function automatic int fallthru_lsb(input int addr_w);
        return 0 * addr_w;
    endfunction

    function automatic int target_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int taken_bit(input int addr_w);
        return 2 * addr_w;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// In-order circular queue of in-flight predictions. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate count.
module bru_pred_fifo
    import branch_resolve_unit_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q[IDX_W-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX branch outcomes against the oldest recorded IF prediction, raising
// a registered flush/redirect on mispredict and feeding the actual outcome back.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              pred_valid,
    input  logic              pred_taken,
    input  logic [ADDR_W-1:0] pred_target,
    input  logic [ADDR_W-1:0] pred_fallthru,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    output logic              full,
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              upd_valid,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt,
    output logic              err_flag
);

    localparam int ENTRY_W = entry_w(ADDR_W);
    localparam int FT_LSB  = fallthru_lsb(ADDR_W);
    localparam int TGT_LSB = target_lsb(ADDR_W);
    localparam int TK_BIT  = taken_bit(ADDR_W);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        return (en && (cnt != {CNT_W{1'b1}})) ? cnt + CNT_W'(1) : cnt;
    endfunction

    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    logic               rd_taken;
    logic [ADDR_W-1:0]  rd_target, rd_fallthru, correct_pc;
    logic               pop_ok, push_ok, mispredict, push_err, pop_err;

    logic               flush_q, upd_valid_q, upd_taken_q, err_q;
    logic [ADDR_W-1:0]  redirect_q;
    logic [CNT_W-1:0]   branch_cnt_q, mispred_cnt_q;

    assign wr_entry    = {pred_taken, pred_target, pred_fallthru};
    assign rd_taken    = rd_entry[TK_BIT];
    assign rd_target   = rd_entry[TGT_LSB +: ADDR_W];
    assign rd_fallthru = rd_entry[FT_LSB +: ADDR_W];

    assign pop_ok     = res_valid && !stall && !fifo_empty;
    assign mispredict = pop_ok && ((rd_taken != res_taken) ||
                        (rd_taken == TAKEN && res_taken == TAKEN && rd_target != res_target));
    // A pop frees a slot in the same edge, so push is legal when full; a mispredict squashes it.
    assign push_ok    = pred_valid && !stall && (!fifo_full || pop_ok) && !mispredict;
    assign push_err   = pred_valid && !stall && fifo_full && !pop_ok;
    assign pop_err    = res_valid && !stall && fifo_empty;
    assign correct_pc = (res_taken == TAKEN) ? res_target : rd_fallthru;

    bru_pred_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push_ok),
        .pop_i     (pop_ok),
        .clear_i   (mispredict),
        .wr_data_i (wr_entry),
        .rd_data_o (rd_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q       <= 1'b0;
            upd_valid_q   <= 1'b0;
            upd_taken_q   <= NOT_TAKEN;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            flush_q       <= mispredict;
            upd_valid_q   <= pop_ok;
            if (pop_ok)     upd_taken_q <= res_taken;
            if (mispredict) redirect_q  <= correct_pc;
            branch_cnt_q  <= sat_inc(branch_cnt_q, pop_ok);
            mispred_cnt_q <= sat_inc(mispred_cnt_q, mispredict);
            if (push_err || pop_err) err_q <= 1'b1;
        end
    end

    assign full        = fifo_full;
    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign upd_valid   = upd_valid_q;
    assign upd_taken   = upd_taken_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign err_flag    = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic, all
// outputs compared each cycle against a queue-based reference model.
module tb_branch_resolve_unit;
    import branch_resolve_unit_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, stall, pred_valid, pred_taken, res_valid, res_taken;
    logic [ADDR_W-1:0] pred_target, pred_fallthru, res_target;
    logic              full, flush, upd_valid, upd_taken, err_flag;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  branch_cnt, mispred_cnt;

    branch_resolve_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_fallthru(pred_fallthru),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .full(full), .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_taken(upd_taken),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .err_flag(err_flag)
    );

    typedef struct {
        logic              tk;
        logic [ADDR_W-1:0] tgt;
        logic [ADDR_W-1:0] ft;
    } ent_t;

    ent_t              mq[$];
    int                m_bc, m_mc;
    logic              m_err, m_flush, m_upd_v, m_upd_t;
    logic [ADDR_W-1:0] m_redir;
    int                checks = 0;
    int                errors = 0;
    string             phase  = "init";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pt, input logic [ADDR_W-1:0] ptg,
                         input logic [ADDR_W-1:0] pft, input logic rv, input logic rt,
                         input logic [ADDR_W-1:0] rtg);
        pred_valid = pv; pred_taken = pt; pred_target = ptg; pred_fallthru = pft;
        res_valid  = rv; res_taken  = rt; res_target  = rtg;
    endtask

    // Advance one clock: update the model from the current inputs, then compare.
    task automatic cycle();
        ent_t e;
        bit   pop, push, mis;
        m_flush = 1'b0;
        m_upd_v = 1'b0;
        if (rst) begin
            mq.delete();
            m_bc = 0; m_mc = 0; m_err = 1'b0; m_redir = '0; m_upd_t = 1'b0;
        end else if (!stall) begin
            pop  = res_valid && (mq.size() > 0);
            push = pred_valid && (mq.size() < DEPTH || pop);
            if (pred_valid && mq.size() == DEPTH && !pop) m_err = 1'b1;
            if (res_valid && mq.size() == 0)              m_err = 1'b1;
            if (pop) begin
                e = mq.pop_front();
                mis = (e.tk != res_taken) || (e.tk && res_taken && e.tgt != res_target);
                m_upd_v = 1'b1;
                m_upd_t = res_taken;
                if (m_bc < CMAX) m_bc++;
                if (mis) begin
                    m_flush = 1'b1;
                    m_redir = res_taken ? res_target : e.ft;
                    if (m_mc < CMAX) m_mc++;
                    mq.delete();
                    push = 1'b0;
                end
            end
            if (push) mq.push_back('{pred_taken, pred_target, pred_fallthru});
        end
        @(posedge clk);
        #1;
        check("full",        full,        mq.size() == DEPTH);
        check("flush",       flush,       m_flush);
        check("redirect_pc", redirect_pc, m_redir);
        check("upd_valid",   upd_valid,   m_upd_v);
        if (m_upd_v || rst) check("upd_taken", upd_taken, m_upd_t);
        check("branch_cnt",  branch_cnt,  m_bc);
        check("mispred_cnt", mispred_cnt, m_mc);
        check("err_flag",    err_flag,    m_err);
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; idle(); cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; idle();

        phase = "t1";
        do_reset();
        check("rst_full", full, 0);
        check("rst_cnt", branch_cnt, 0);
        drive(1, TAKEN, 32'h100, 32'h24, 0, 0, '0); cycle();
        drive(0, 0, '0, '0, 1, TAKEN, 32'h100);     cycle();
        check("upd_valid_k", upd_valid, 1);
        check("upd_taken_k", upd_taken, 1);
        check("flush_k", flush, 0);
        check("bc_k", branch_cnt, 1);
        check("mc_k", mispred_cnt, 0);

        phase = "t2";
        drive(1, NOT_TAKEN, 32'h200, 32'h40, 0, 0, '0); cycle();
        drive(0, 0, '0, '0, 1, TAKEN, 32'h200);         cycle();
        check("flush_k", flush, 1);
        check("redir_k", redirect_pc, 32'h200);
        check("mc_k", mispred_cnt, 1);
        idle(); cycle();
        check("flush_drop", flush, 0);
        check("redir_hold", redirect_pc, 32'h200);

        phase = "t3";
        drive(1, TAKEN, 32'h300, 32'h50, 0, 0, '0); cycle();
        drive(0, 0, '0, '0, 1, NOT_TAKEN, 32'h999); cycle();
        check("flush_k", flush, 1);
        check("redir_k", redirect_pc, 32'h50);

        phase = "t4";
        for (int i = 0; i < 3; i++) begin
            drive(1, TAKEN, 32'h400 + 32'(i), 32'h60, 0, 0, '0); cycle();
        end
        drive(1, TAKEN, 32'h4ff, 32'h64, 1, NOT_TAKEN, '0); cycle();
        check("flush_k", flush, 1);
        check("full_k", full, 0);
        idle(); res_valid = 1'b1; cycle();
        check("err_k", err_flag, 1);
        check("no_upd", upd_valid, 0);
        check("no_flush", flush, 0);

        phase = "t5";
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, logic'(i % 2), 32'h1000 * 32'(i + 1), 32'h10 * 32'(i + 1), 0, 0, '0); cycle();
        end
        check("full_k", full, 1);
        drive(1, TAKEN, 32'hdead, 32'hbeef, 0, 0, '0); cycle();
        check("err_k", err_flag, 1);
        check("full_hold", full, 1);
        drive(1, TAKEN, 32'h5000, 32'h70, 1, NOT_TAKEN, '0); cycle();
        check("full_pp", full, 1);
        check("flush_pp", flush, 0);
        for (int i = 1; i < DEPTH; i++) begin
            drive(0, 0, '0, '0, 1, logic'(i % 2), 32'h1000 * 32'(i + 1)); cycle();
            check("order_flush", flush, 0);
        end
        drive(0, 0, '0, '0, 1, TAKEN, 32'h5000); cycle();
        check("order_last", flush, 0);
        check("bc_k", branch_cnt, 5);

        phase = "t6";
        do_reset();
        drive(1, TAKEN, 32'h800, 32'h80, 0, 0, '0); cycle(); cycle();
        stall = 1'b1;
        drive(1, TAKEN, 32'h900, 32'h90, 1, NOT_TAKEN, '0); cycle();
        check("stall_upd", upd_valid, 0);
        check("stall_flush", flush, 0);
        check("stall_bc", branch_cnt, 0);
        stall = 1'b0; idle();
        drive(0, 0, '0, '0, 1, NOT_TAKEN, '0); cycle();
        check("mid_flush", flush, 1);
        rst = 1'b1; idle(); cycle();
        check("rst_redir", redirect_pc, 0);
        check("rst_mc", mispred_cnt, 0);
        rst = 1'b0;

        phase = "rand";
        for (int n = 0; n < 4000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 2) != 0, logic'($urandom_range(0, 1)),
                  32'h100 * 32'($urandom_range(1, 2)), 32'($urandom),
                  $urandom_range(0, 2) != 0, logic'($urandom_range(0, 1)),
                  32'h100 * 32'($urandom_range(1, 2)));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
